// File: rtl/zero_det_pkg.sv
// Shared types for the serial zero-after-ones detector.
// State encoding is fixed so the register contents stay meaningful on a debug probe.
package zero_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,  // idle, no 1 seen
    S1 = 2'b01,  // one 1 seen
    S2 = 2'b10,  // three or more 1s seen
    S3 = 2'b11   // two 1s seen
  } state_t;

  localparam state_t RESET_STATE = S0;

endpackage

// File: rtl/mealy_zero_detector_sb.sv
// Mealy detector: pulses y_out combinationally when a 0 arrives after one or more 1s.
// Any detect or reset returns the machine to idle.
module mealy_zero_detector_sb
  import zero_det_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic x_in,
  output logic y_out
);

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    y_out      = 1'b0;
    unique case (state_reg)
      S0: begin
        state_next = x_in ? S1 : S0;
      end
      S1: begin
        state_next = x_in ? S3 : S0;
        y_out      = ~x_in;
      end
      S3: begin
        state_next = x_in ? S2 : S0;
        y_out      = ~x_in;
      end
      S2: begin
        state_next = x_in ? S2 : S0;
        y_out      = ~x_in;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
    // Reset masks the pulse even before the reset edge lands.
    if (reset) begin
      y_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_mealy_zero_detector_sb.sv
// Directed and random checks for mealy_zero_detector_sb against hand values and a run-length model.
module tb_mealy_zero_detector_sb;

  logic clock;
  logic reset;
  logic x_in;
  logic y_out;

  int checks_total;
  int checks_passed;

  mealy_zero_detector_sb dut (
    .clock (clock),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [1:0] ST_S0 = 2'b00;
  localparam logic [1:0] ST_S1 = 2'b01;
  localparam logic [1:0] ST_S2 = 2'b10;
  localparam logic [1:0] ST_S3 = 2'b11;

  task automatic check(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one bit, check the Mealy output before the edge, then the state after it.
  task automatic step(input string tag, input logic r, input logic x,
                      input logic exp_y, input logic [1:0] exp_state);
    logic [1:0] st;
    reset = r;
    x_in  = x;
    #2;
    check({tag, " y_out"}, {1'b0, y_out}, {1'b0, exp_y});
    @(posedge clock);
    #1;
    st = dut.state_reg;
    check({tag, " state"}, st, exp_state);
    $display("t=%0t %s reset=%0b x_in=%0b y_out=%0b state=%0d", $time, tag, r, x, exp_y, st);
  endtask

  function automatic logic [1:0] state_of_count(input int ones);
    if (ones == 0)      return ST_S0;
    else if (ones == 1) return ST_S1;
    else if (ones == 2) return ST_S3;
    else                return ST_S2;
  endfunction

  initial begin
    int ones;
    logic r;
    logic x;
    logic ey;

    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b1;
    x_in  = 1'b0;

    for (int i = 0; i < 5; i++) step("reset_hold", 1'b1, 1'b0, 1'b0, ST_S0);

    step("single_1", 1'b0, 1'b1, 1'b0, ST_S1);
    step("single_0", 1'b0, 1'b0, 1'b1, ST_S0);
    step("single_after", 1'b0, 1'b0, 1'b0, ST_S0);

    step("run_1a", 1'b0, 1'b1, 1'b0, ST_S1);
    step("run_1b", 1'b0, 1'b1, 1'b0, ST_S3);
    step("run_1c", 1'b0, 1'b1, 1'b0, ST_S2);
    step("run_1d", 1'b0, 1'b1, 1'b0, ST_S2);
    step("run_1e", 1'b0, 1'b1, 1'b0, ST_S2);
    step("run_0", 1'b0, 1'b0, 1'b1, ST_S0);

    for (int i = 0; i < 5; i++) step("idle_0", 1'b0, 1'b0, 1'b0, ST_S0);

    step("mid_1a", 1'b0, 1'b1, 1'b0, ST_S1);
    step("mid_1b", 1'b0, 1'b1, 1'b0, ST_S3);
    step("mid_reset", 1'b1, 1'b0, 1'b0, ST_S0);
    step("mid_release", 1'b0, 1'b0, 1'b0, ST_S0);

    step("s2_1a", 1'b0, 1'b1, 1'b0, ST_S1);
    step("s2_1b", 1'b0, 1'b1, 1'b0, ST_S3);
    step("s2_1c", 1'b0, 1'b1, 1'b0, ST_S2);
    step("s2_reset_x1", 1'b1, 1'b1, 1'b0, ST_S0);

    ones = 0;
    for (int i = 0; i < 200; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      x  = $urandom_range(0, 1);
      ey = !r && !x && (ones > 0);
      if (r)      ones = 0;
      else if (x) ones = ones + 1;
      else        ones = 0;
      step("rand", r, x, ey, state_of_count(ones));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
